// File: rtl/cnn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cnn_pkg: shared constants and FSM state type for the USB frame loader |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package cnn_pkg;

  localparam int         IMAGE_PIXELS = 784;
  localparam int         NUM_CLASSES  = 10;
  localparam logic [7:0] SYNC_BYTE    = 8'hA5;
  localparam int         ADDR_W       = 10;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_LABEL    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PIXELS = 2'd1,
    ST_LABEL  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/frame_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_bank: one image buffer, single write port, registered read port |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module frame_bank
  import cnn_pkg::*;
#(
  parameter int DEPTH = IMAGE_PIXELS,
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Out-of-range addresses read as zero rather than aliasing into the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (raddr_i <= LAST_ADDR) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/usb_frame_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_frame_loader: USB byte stream to ping-pong image banks for a CNN  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module usb_frame_loader
  import cnn_pkg::*;
#(
  parameter int         IMAGE_PIXELS   = cnn_pkg::IMAGE_PIXELS,
  parameter int         NUM_CLASSES    = cnn_pkg::NUM_CLASSES,
  parameter logic [7:0] SYNC_BYTE      = cnn_pkg::SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  usb_data_in,
  input  logic        usb_data_valid,
  output logic        usb_data_ready,
  input  logic        mode_train,
  output logic        frame_valid,
  output logic        frame_train,
  output logic [3:0]  frame_label,
  input  logic [9:0]  rd_addr,
  output logic [7:0]  rd_data,
  input  logic        frame_done,
  output logic        rx_error,
  output logic [1:0]  err_code,
  output logic [15:0] frame_count
);

  localparam int                TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(IMAGE_PIXELS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]        NUM_CLS_B = 8'(NUM_CLASSES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              mode_q, mode_d;
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, rd_bank_q, rd_sel_q;
  logic [1:0]        train_q;
  logic [3:0]        label_q [2];
  logic [15:0]       count_q;
  logic              rx_err_q;
  logic [1:0]        err_q;

  logic              accept, commit, drop, done_eff, pix_we;
  logic [1:0]        drop_code;
  logic [7:0]        bank_rdata [2];

  assign usb_data_ready = !full_q[wr_bank_q];
  assign accept         = usb_data_valid && usb_data_ready;
  assign done_eff       = frame_done && full_q[rd_bank_q];
  assign frame_valid    = full_q[rd_bank_q];
  assign frame_train    = train_q[rd_bank_q];
  assign frame_label    = label_q[rd_bank_q];
  assign rd_data        = rd_sel_q ? bank_rdata[1] : bank_rdata[0];
  assign rx_error       = rx_err_q;
  assign err_code       = err_q;
  assign frame_count    = count_q;

  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    tmo_d     = tmo_q;
    mode_d    = mode_q;
    commit    = 1'b0;
    drop      = 1'b0;
    drop_code = ERR_NONE;
    pix_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (accept && (usb_data_in == SYNC_BYTE)) begin
          mode_d  = mode_train;
          pix_d   = '0;
          state_d = ST_PIXELS;
        end
      end
      ST_PIXELS: begin
        if (accept) begin
          pix_we = 1'b1;
          tmo_d  = '0;
          if (pix_q == LAST_PIX) begin
            if (mode_q) begin
              state_d = ST_LABEL;
            end else begin
              commit  = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          drop      = 1'b1;
          drop_code = ERR_TIMEOUT;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_LABEL: begin
        if (accept) begin
          tmo_d   = '0;
          state_d = ST_IDLE;
          if (usb_data_in < NUM_CLS_B) begin
            commit = 1'b1;
          end else begin
            drop      = 1'b1;
            drop_code = ERR_LABEL;
          end
        end else if (tmo_q == TMO_LAST) begin
          drop      = 1'b1;
          drop_code = ERR_TIMEOUT;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Commit and release never target the same bank: commit needs an empty write bank.
  always_comb begin
    full_d = full_q;
    if (done_eff) full_d[rd_bank_q] = 1'b0;
    if (commit)   full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pix_q      <= '0;
      tmo_q      <= '0;
      mode_q     <= 1'b0;
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_sel_q   <= 1'b0;
      train_q    <= '0;
      label_q[0] <= '0;
      label_q[1] <= '0;
      count_q    <= '0;
      rx_err_q   <= 1'b0;
      err_q      <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      pix_q    <= pix_d;
      tmo_q    <= tmo_d;
      mode_q   <= mode_d;
      full_q   <= full_d;
      rd_sel_q <= rd_bank_q;
      rx_err_q <= drop;
      if (drop) begin
        err_q <= drop_code;
      end
      if (commit) begin
        wr_bank_q          <= ~wr_bank_q;
        count_q            <= count_q + 16'd1;
        train_q[wr_bank_q] <= mode_q;
        label_q[wr_bank_q] <= mode_q ? usb_data_in[3:0] : 4'd0;
      end
      if (done_eff) begin
        rd_bank_q <= ~rd_bank_q;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    frame_bank #(
      .DEPTH (IMAGE_PIXELS),
      .WIDTH (8)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (pix_we && (wr_bank_q == 1'(gi))),
      .waddr_i (pix_q),
      .wdata_i (usb_data_in),
      .raddr_i (rd_addr),
      .rdata_o (bank_rdata[gi])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_frame_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_usb_frame_loader: randomized + directed bench with frame-queue model|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_usb_frame_loader;

  localparam int NPIX = 784;
  localparam int TMO  = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  usb_data_in = 8'd0;
  logic        usb_data_valid = 1'b0;
  logic        usb_data_ready;
  logic        mode_train = 1'b0;
  logic        frame_valid, frame_train;
  logic [3:0]  frame_label;
  logic [9:0]  rd_addr = 10'd0;
  logic [7:0]  rd_data;
  logic        frame_done = 1'b0;
  logic        rx_error;
  logic [1:0]  err_code;
  logic [15:0] frame_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_en = 1'b0;
  int cur_seed = 0;

  usb_frame_loader #(
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .usb_data_in    (usb_data_in),
    .usb_data_valid (usb_data_valid),
    .usb_data_ready (usb_data_ready),
    .mode_train     (mode_train),
    .frame_valid    (frame_valid),
    .frame_train    (frame_train),
    .frame_label    (frame_label),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .frame_done     (frame_done),
    .rx_error       (rx_error),
    .err_code       (err_code),
    .frame_count    (frame_count)
  );

  always #5 clk = ~clk;

  // Frame content is a pure function of a per-frame seed; seed 0 gives i%256.
  function automatic logic [7:0] pix_of(input int seed, input int i);
    return 8'(i + seed * 37) ^ 8'(seed);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of presented frames ----------------
  int         qs[$];
  int         qt[$];
  int         ql[$];
  bit         m_in = 1'b0;
  bit         m_mode = 1'b0;
  int         m_seed = 0;
  int         m_npix = 0;
  int         m_idle = 0;
  int         m_cnt = 0;
  bit         m_rx = 1'b0;
  int         m_err = 0;
  int         m_rd = 0;
  bit         m_rdchk = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qs.delete(); qt.delete(); ql.delete();
      m_in = 1'b0; m_cnt = 0; m_rx = 1'b0; m_err = 0;
      m_rd = 0; m_rdchk = 1'b1; m_idle = 0;
    end else begin : step
      bit acc;
      bit do_commit;
      int lab;
      acc       = usb_data_valid && (qs.size() < 2);
      m_rdchk   = (int'(rd_addr) >= NPIX) || (qs.size() > 0);
      m_rd      = (int'(rd_addr) >= NPIX) ? 0 :
                  ((qs.size() > 0) ? int'(pix_of(qs[0], int'(rd_addr))) : 0);
      m_rx      = 1'b0;
      do_commit = 1'b0;
      lab       = 0;
      if (!m_in) begin
        if (acc && usb_data_in == 8'hA5) begin
          m_in = 1'b1; m_mode = mode_train; m_seed = cur_seed; m_npix = 0; m_idle = 0;
        end
      end else if (acc) begin
        m_idle = 0;
        if (m_npix < NPIX) begin
          m_npix++;
          if (m_npix == NPIX && !m_mode) begin
            do_commit = 1'b1; m_in = 1'b0;
          end
        end else begin
          m_in = 1'b0;
          if (int'(usb_data_in) < 10) begin
            do_commit = 1'b1; lab = int'(usb_data_in);
          end else begin
            m_rx = 1'b1; m_err = 1;
          end
        end
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          m_in = 1'b0; m_rx = 1'b1; m_err = 2;
        end
      end
      if (frame_done && qs.size() > 0) begin
        void'(qs.pop_front()); void'(qt.pop_front()); void'(ql.pop_front());
      end
      if (do_commit) begin
        qs.push_back(m_seed); qt.push_back(int'(m_mode)); ql.push_back(lab);
        m_cnt = (m_cnt + 1) & 16'hFFFF;
      end
    end
  end

  always @(negedge clk) begin
    chk("ready", int'(usb_data_ready), int'(qs.size() < 2));
    chk("frame_valid", int'(frame_valid), int'(qs.size() > 0));
    if (qs.size() > 0) begin
      chk("frame_train", int'(frame_train), qt[0]);
      chk("frame_label", int'(frame_label), ql[0]);
    end
    chk("frame_count", int'(frame_count), m_cnt);
    chk("rx_error", int'(rx_error), int'(m_rx));
    chk("err_code", int'(err_code), m_err);
    if (m_rdchk) chk("rd_data", int'(rd_data), m_rd);
  end

  // ---------------- stimulus ----------------
  task automatic align();
    @(posedge clk); #2;
  endtask

  // Caller must be at posedge+2; returns at posedge+2 after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input bit dn);
    int n;
    n = 0;
    usb_data_in    = b;
    usb_data_valid = 1'b1;
    frame_done     = dn;
    if (rand_en) rd_addr = 10'($urandom_range(0, 1023));
    forever begin
      @(negedge clk);
      if (usb_data_ready) break;
      n++;
      if (n > 4000) begin
        chk("ready_wait_timeout", 0, 1);
        break;
      end
      if (rand_en) frame_done = !frame_done && ($urandom_range(0, 7) == 0);
    end
    @(posedge clk); #2;
    usb_data_valid = 1'b0;
    frame_done     = 1'b0;
  endtask

  task automatic send_frame(input int seed, input bit train, input logic [7:0] label,
                            input bit gaps, input bit last_dn);
    align();
    mode_train = train;
    cur_seed   = seed;
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < NPIX; i++) begin
      if (gaps && $urandom_range(0, 15) == 0) begin
        usb_data_in = 8'($urandom);
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #2; end
      end
      send_byte(pix_of(seed, i), (!train && i == NPIX - 1) ? last_dn
                                 : (rand_en && $urandom_range(0, 63) == 0));
    end
    if (train) send_byte(label, last_dn);
  endtask

  task automatic pulse_done();
    @(posedge clk); #2 frame_done = 1'b1;
    @(posedge clk); #2 frame_done = 1'b0;
  endtask

  task automatic read_px(input logic [9:0] a, output logic [7:0] d);
    @(posedge clk); #2 rd_addr = a;
    @(posedge clk);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    usb_data_valid = 1'b0; frame_done = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] d;
    int n;
    do_reset();
    @(negedge clk);
    chk("rst_ready", int'(usb_data_ready), 1);
    chk("rst_valid", int'(frame_valid), 0);
    chk("rst_count", int'(frame_count), 0);

    // Inference frame with i%256 pixels
    send_frame(0, 1'b0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("inf_valid", int'(frame_valid), 1);
    chk("inf_label", int'(frame_label), 0);
    chk("inf_train", int'(frame_train), 0);
    chk("inf_count", int'(frame_count), 1);
    read_px(10'd300, d);  chk("inf_px300", int'(d), 8'h2C);
    read_px(10'd900, d);  chk("inf_px_oob", int'(d), 0);
    pulse_done();
    @(negedge clk); chk("inf_released", int'(frame_valid), 0);

    // Train frame, good and bad labels
    send_frame(5, 1'b1, 8'd7, 1'b0, 1'b0);
    @(negedge clk);
    chk("train_train", int'(frame_train), 1);
    chk("train_label", int'(frame_label), 7);
    pulse_done();
    send_frame(6, 1'b1, 8'd12, 1'b0, 1'b0);
    @(negedge clk);
    chk("badlbl_rx", int'(rx_error), 1);
    chk("badlbl_code", int'(err_code), 1);
    chk("badlbl_valid", int'(frame_valid), 0);
    @(negedge clk); chk("badlbl_pulse", int'(rx_error), 0);

    // Back-to-back frames with no release
    do_reset();
    send_frame(11, 1'b0, 8'd0, 1'b0, 1'b0);
    send_frame(12, 1'b0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_ready_low", int'(usb_data_ready), 0);
    read_px(10'd10, d); chk("bp_first_px", int'(d), int'(pix_of(11, 10)));
    pulse_done();
    @(negedge clk);
    chk("bp_ready_high", int'(usb_data_ready), 1);
    chk("bp_valid", int'(frame_valid), 1);
    read_px(10'd10, d); chk("bp_second_px", int'(d), int'(pix_of(12, 10)));
    send_frame(13, 1'b0, 8'd0, 1'b0, 1'b0);
    @(negedge clk); chk("bp_count", int'(frame_count), 3);
    pulse_done(); pulse_done();

    // Stall mid-frame until timeout
    align();
    mode_train = 1'b0; cur_seed = 50;
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i <= 100; i++) send_byte(pix_of(50, i), 1'b0);
    n = 0;
    while (n < TMO + 20) begin
      @(negedge clk);
      if (rx_error) break;
      n++;
    end
    chk("tmo_seen", int'(rx_error), 1);
    chk("tmo_latency", n, TMO);
    chk("tmo_code", int'(err_code), 2);
    send_frame(21, 1'b0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("tmo_next_valid", int'(frame_valid), 1);
    chk("tmo_next_count", int'(frame_count), 4);
    pulse_done();

    // Commit and release on the same edge
    do_reset();
    send_frame(30, 1'b0, 8'd0, 1'b0, 1'b0);
    send_frame(31, 1'b0, 8'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("same_count", int'(frame_count), 2);
    chk("same_valid", int'(frame_valid), 1);
    chk("same_ready", int'(usb_data_ready), 1);
    read_px(10'd7, d); chk("same_px", int'(d), int'(pix_of(31, 7)));
    pulse_done();

    // Reset in the middle of a frame
    align();
    mode_train = 1'b0; cur_seed = 40;
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 500; i++) send_byte(pix_of(40, i), 1'b0);
    do_reset();
    @(negedge clk);
    chk("midrst_ready", int'(usb_data_ready), 1);
    chk("midrst_valid", int'(frame_valid), 0);
    send_frame(41, 1'b0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("midrst_next_valid", int'(frame_valid), 1);
    chk("midrst_next_count", int'(frame_count), 1);

    // Randomized traffic
    rand_en = 1'b1;
    repeat (8) begin
      logic [7:0] g;
      logic [7:0] lab;
      align();
      repeat ($urandom_range(0, 3)) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        send_byte(g, 1'b0);
      end
      lab = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(10, 255)) : 8'($urandom_range(0, 9));
      send_frame($urandom_range(1, 200), 1'($urandom_range(0, 1)), lab, 1'b1, 1'b0);
    end
    rand_en = 1'b0;
    repeat (3) begin
      if (frame_valid) pulse_done();
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usb_frame_loader.md
USB_FRAME_LOADER -- requirements
Module: usb_frame_loader

Interface
REQ-001 Parameter IMAGE_PIXELS, 784: pixel bytes per frame.
REQ-002 Parameter NUM_CLASSES, 10: valid label range is 0..NUM_CLASSES-1.
REQ-003 Parameter SYNC_BYTE, 8'hA5: frame-start marker.
REQ-004 Parameter TIMEOUT_CYCLES, 65535: max idle cycles between bytes inside a frame.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 usb_data_in  in  8  USB byte (sync, pixel or label).
REQ-008 usb_data_valid  in  1  usb_data_in valid this cycle.
REQ-009 usb_data_ready  out  1  loader can accept a byte; transfer occurs when valid && ready.
REQ-010 mode_train  in  1  1 = frame carries trailing label byte; sampled when the sync byte is accepted.
REQ-011 frame_valid  out  1  a complete frame is presented to the CNN.
REQ-012 frame_train  out  1  presented frame was captured in training mode.
REQ-013 frame_label  out  4  label of presented frame (0 when frame_train = 0).
REQ-014 rd_addr  in  10  pixel index into the presented frame.
REQ-015 rd_data  out  8  pixel at rd_addr; 1-cycle read latency.
REQ-016 frame_done  in  1  single-cycle pulse from CNN releasing the presented frame.
REQ-017 rx_error  out  1  one-cycle pulse on a dropped frame.
REQ-018 err_code  out  2  01 = bad label, 10 = timeout; holds until the next error.
REQ-019 frame_count  out  16  committed frames, wraps at 65535 -> 0.

Function
REQ-020 Two frame banks (ping-pong); the write bank is wr_bank, the presented bank is rd_bank, and each bank has a full flag.
REQ-021 usb_data_ready = !full[wr_bank] in every state.
REQ-022 FSM states: IDLE, PIXELS, LABEL.
REQ-023 IDLE: an accepted byte equal to SYNC_BYTE latches mode_train, clears the pixel counter, goes to PIXELS; any other byte is discarded.
REQ-024 PIXELS: each accepted byte is written to wr_bank[pix_cnt] and pix_cnt increments.
REQ-025 On byte IMAGE_PIXELS-1: go to LABEL if the latched mode is train, else commit.
REQ-026 LABEL: an accepted byte < NUM_CLASSES is stored as the bank label and commits; a byte >= NUM_CLASSES drops the frame, pulses rx_error with err_code = 01, and goes to IDLE.
REQ-027 Commit, on the edge accepting the final byte: set full[wr_bank], toggle wr_bank, increment frame_count, go to IDLE.
REQ-028 frame_valid = full[rd_bank], so it is high on the edge after the final byte is accepted when rd_bank was empty.
REQ-029 frame_done while frame_valid clears full[rd_bank] and toggles rd_bank; frame_done while !frame_valid is ignored.
REQ-030 When commit and frame_done fall on the same edge, both take effect.
REQ-031 When both banks are full, usb_data_ready = 0 until frame_done.
REQ-032 Timeout counter: cleared on each accepted byte and in IDLE; at TIMEOUT_CYCLES in PIXELS or LABEL it drops the frame, pulses rx_error with err_code = 10, and goes to IDLE.
REQ-033 A dropped frame leaves the bank flags, wr_bank and frame_count unchanged.
REQ-034 A SYNC_BYTE value received inside PIXELS or LABEL is treated as data.
REQ-035 rd_data reads the rd_bank selected at the read edge; rd_addr >= IMAGE_PIXELS returns 0.

Reset
REQ-036 While rst_n = 0: state = IDLE; counters, wr_bank, rd_bank and full flags = 0; all outputs 0 except usb_data_ready = 1 after release; bank contents are not reset.
REQ-037 Reset mid-frame discards the partial frame.

Structure
REQ-038 Package cnn_pkg holds IMAGE_PIXELS, NUM_CLASSES, SYNC_BYTE, the err_code constants and the FSM state enum.
REQ-039 Sub-module frame_bank (784x8, one write port, one registered read port) is instantiated twice.

Verification
REQ-040 Inference frame (A5, 784 bytes i%256): frame_valid = 1 one edge after the last byte; rd_addr = 300 -> rd_data = 8'h2C; frame_label = 0; frame_count = 1.
REQ-041 Train frame with label 7: frame_train = 1, frame_label = 7; label byte 12 instead -> rx_error pulse, err_code = 01, frame_valid stays 0.
REQ-042 Three back-to-back frames with no frame_done: usb_data_ready = 0 after the 2nd commit; one frame_done -> ready = 1 and frame_valid stays 1 showing frame 2.
REQ-043 Stall after pixel 100 for TIMEOUT_CYCLES: rx_error pulse, err_code = 10; the next A5 frame completes normally.
REQ-044 Commit and frame_done on the same edge: frame_count increments, the other bank is presented, no frame is lost.
REQ-045 rst_n low at pixel 500: usb_data_ready = 1 and frame_valid = 0; the following full frame is accepted.
